muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the RV64 word (W) variants.
- Uses a valid/ready handshake so the pipeline can stall on busy and on result backpressure.
- Computes one result bit per cycle (shift-add multiply, restoring divide), with short-circuit paths for the divide corner cases.

---
 rtl/muldiv_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one result bit per cycle (shift-add multiply,
// restoring divide) with single-edge shortcuts for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int REG_WIDTH = 64,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic                 op_w,
    input  logic [REG_WIDTH-1:0] rs1,
    input  logic [REG_WIDTH-1:0] rs2,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0] tag_out
);
    localparam int CNT_BITS = $clog2(REG_WIDTH) + 1;
    localparam int W        = REG_WIDTH;
    localparam int HALF     = REG_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [2:0]             op_q, op_d;
    logic                   w_q, w_d;
    logic                   neg_q, neg_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [TAG_WIDTH-1:0]   tag_out_q, tag_out_d;
    logic [2*W-1:0]         prod_q, prod_d;
    logic [W:0]             rem_q, rem_d;
    logic [W-1:0]           quo_q, quo_d;
    logic [W-1:0]           dvs_q, dvs_d;
    logic [W-1:0]           result_q, result_d;
    logic                   out_valid_q, out_valid_d;

    logic                   w_eff, a_signed, b_signed, a_neg, b_neg;
    logic                   div_zero, div_ovf;
    logic [W-1:0]           a_ext, b_ext, a_mag, b_mag, min_neg, special_res;
    logic [W:0]             mul_sum;
    logic [2*W-1:0]         mul_step;
    logic [W+1:0]           div_shift, div_diff;
    logic [2*W-1:0]         prod_fix;
    logic [W-1:0]           quo_fix, rem_fix, fix_raw, fix_res;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_out_q;

    // Request decode: W-mode operand extension, magnitudes and divide corner cases.
    always_comb begin
        w_eff    = op_w & (op[2] | (op[1:0] == 2'b00));
        a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
        b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
        if (w_eff) begin
            a_ext = a_signed ? {{HALF{rs1[HALF-1]}}, rs1[HALF-1:0]} : {{HALF{1'b0}}, rs1[HALF-1:0]};
            b_ext = b_signed ? {{HALF{rs2[HALF-1]}}, rs2[HALF-1:0]} : {{HALF{1'b0}}, rs2[HALF-1:0]};
            min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end else begin
            a_ext   = rs1;
            b_ext   = rs2;
            min_neg = {1'b1, {(W-1){1'b0}}};
        end
        a_neg    = a_signed & a_ext[W-1];
        b_neg    = b_signed & b_ext[W-1];
        a_mag    = a_neg ? ({W{1'b0}} - a_ext) : a_ext;
        b_mag    = b_neg ? ({W{1'b0}} - b_ext) : b_ext;
        div_zero = op[2] & (b_ext == {W{1'b0}});
        div_ovf  = op[2] & ~op[0] & (a_ext == min_neg) & (b_ext == {W{1'b1}});
        if (div_zero) begin
            if (op[1]) begin
                special_res = w_eff ? {{HALF{a_ext[HALF-1]}}, a_ext[HALF-1:0]} : a_ext;
            end else begin
                special_res = {W{1'b1}};
            end
        end else begin
            special_res = op[1] ? {W{1'b0}} : a_ext;
        end
    end

    // One iteration step of each algorithm plus the final sign fix / result select.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + {1'b0, dvs_q};
        mul_step  = prod_q[0] ? {mul_sum, prod_q[W-1:1]} : {1'b0, prod_q[2*W-1:1]};
        div_shift = {rem_q, quo_q[W-1]};
        div_diff  = div_shift - {2'b00, dvs_q};
        prod_fix  = neg_q ? ({(2*W){1'b0}} - prod_q) : prod_q;
        quo_fix   = neg_q ? ({W{1'b0}} - quo_q) : quo_q;
        rem_fix   = neg_q ? ({W{1'b0}} - rem_q[W-1:0]) : rem_q[W-1:0];
        case (op_q)
            // In W mode only 32 iterations run, so the low product word sits one half up.
            3'b000:                 fix_raw = w_q ? {{HALF{1'b0}}, prod_fix[W-1:HALF]} : prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fix_raw = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fix_raw = quo_fix;
            default:                fix_raw = rem_fix;
        endcase
        fix_res = w_q ? {{HALF{fix_raw[HALF-1]}}, fix_raw[HALF-1:0]} : fix_raw;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        w_d         = w_q;
        neg_d       = neg_q;
        tag_d       = tag_q;
        tag_out_d   = tag_out_q;
        prod_d      = prod_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    w_d    = w_eff;
                    tag_d  = tag_in;
                    neg_d  = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
                    dvs_d  = op[2] ? b_mag : a_mag;
                    prod_d = {{W{1'b0}}, b_mag};
                    rem_d  = {(W+1){1'b0}};
                    quo_d  = w_eff ? (a_mag << HALF) : a_mag;
                    cnt_d  = w_eff ? CNT_BITS'(HALF) : CNT_BITS'(W);
                    if (div_zero || div_ovf) begin
                        result_d    = special_res;
                        tag_out_d   = tag_in;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        if (div_diff[W+1]) begin
                            rem_d = div_shift[W:0];
                            quo_d = {quo_q[W-2:0], 1'b0};
                        end else begin
                            rem_d = div_diff[W:0];
                            quo_d = {quo_q[W-2:0], 1'b1};
                        end
                    end else begin
                        prod_d = mul_step;
                    end
                    cnt_d = cnt_q - {{(CNT_BITS-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(CNT_BITS-1){1'b0}}, 1'b1}) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d    = fix_res;
                    tag_out_d   = tag_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_BITS{1'b0}};
            op_q        <= 3'b000;
            w_q         <= 1'b0;
            neg_q       <= 1'b0;
            tag_q       <= {TAG_WIDTH{1'b0}};
            tag_out_q   <= {TAG_WIDTH{1'b0}};
            prod_q      <= {(2*W){1'b0}};
            rem_q       <= {(W+1){1'b0}};
            quo_q       <= {W{1'b0}};
            dvs_q       <= {W{1'b0}};
            result_q    <= {W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            w_q         <= w_d;
            neg_q       <= neg_d;
            tag_q       <= tag_d;
            tag_out_q   <= tag_out_d;
            prod_q      <= prod_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, corner cases,
// latency, backpressure, flush and asynchronous reset.
module tb_muldiv_unit;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        op_w;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [4:0]  tag_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_w(op_w), .rs1(rs1), .rs2(rs2), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present a request and let one edge accept it; ends #1 after the accept edge.
    task automatic issue(input string name, input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
        op = o; op_w = w; rs1 = a; rs2 = b; tag_in = t; in_valid = 1'b1;
        check_eq({name, "_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq({name, "_busy"}, {63'd0, in_ready}, 64'd0);
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(input string name, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic retire(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({name, "_drop"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                       input logic [63:0] exp_res, input int exp_lat);
        issue(name, o, w, a, b, t);
        wait_valid(name, exp_lat);
        check_eq({name, "_res"}, result, exp_res);
        check_eq({name, "_tag"}, {59'd0, tag_out}, {59'd0, t});
        retire(name);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; op_w = 1'b0; rs1 = 64'd0; rs2 = 64'd0; tag_in = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_tag", {59'd0, tag_out}, 64'd0);
        check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        run("mul",    3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run("mulhu",  3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run("mulh",   3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'd0, 65);
        run("mulhsu", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("div",    3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("rem",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("divu",   3'b101, 1'b0, 64'd100, 64'd7, 5'd7, 64'd14, 65);
        run("remu",   3'b111, 1'b0, 64'd100, 64'd7, 5'd8, 64'd2, 65);
        // Corner cases finish on the accept edge itself.
        run("div0",   3'b100, 1'b0, 64'd42, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run("rem0",   3'b110, 1'b0, 64'd5, 64'd0, 5'd10, 64'd5, 0);
        run("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'h8000_0000_0000_0000, 0);
        run("removf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'd0, 0);
        // Word mode.
        run("mulw",   3'b000, 1'b1, 64'h1_0000, 64'h1_0000, 5'd13, 64'd0, 33);
        run("mulwsx", 3'b000, 1'b1, 64'h0000_0000_8000_0000, 64'hDEAD_0000_0000_0001, 5'd14, 64'hFFFF_FFFF_8000_0000, 33);
        run("divwovf",3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd15, 64'hFFFF_FFFF_8000_0000, 0);
        run("divuw",  3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'd16, 64'h0000_0000_7FFF_FFFF, 33);
        run("remw",   3'b110, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("mulhuw", 3'b011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 64'hFFFF_FFFF_FFFF_FFFE, 65);

        // Backpressure in DONE, then a request queued during the handshake edge.
        issue("hold", 3'b101, 1'b0, 64'd100, 64'd7, 5'd19);
        wait_valid("hold", 65);
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_res", result, 64'd14);
        check_eq("hold_tag", {59'd0, tag_out}, 64'd19);
        check_eq("hold_flags", {62'd0, out_valid, in_ready}, 64'd2);
        out_ready = 1'b1;
        op = 3'b111; op_w = 1'b0; rs1 = 64'd100; rs2 = 64'd7; tag_in = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("hs_flags", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("b2b_busy", {63'd0, in_ready}, 64'd0);
        wait_valid("b2b", 65);
        check_eq("b2b_res", result, 64'd2);
        check_eq("b2b_tag", {59'd0, tag_out}, 64'd20);
        retire("b2b");

        // Flush at the tenth CALC iteration.
        issue("flush", 3'b000, 1'b0, 64'd3, 64'd4, 5'd21);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_idle", {62'd0, out_valid, in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("flush_novalid", {63'd0, seen}, 64'd0);

        // Flush in IDLE blocks acceptance.
        op = 3'b000; op_w = 1'b0; rs1 = 64'd1; rs2 = 64'd1; tag_in = 5'd22;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_block", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset in the middle of CALC.
        issue("rstmid", 3'b100, 1'b0, 64'd1000, 64'd3, 5'd23);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstmid_async", {62'd0, out_valid, in_ready}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rstmid_rel", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        run("after_rst", 3'b100, 1'b0, 64'd1000, 64'd3, 5'd24, 64'd333, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
